// File: rtl/sort_scheduler_pkg.sv
// Shared definitions for the sort_scheduler block: FSM state encoding,
// the sort unit's lane count and a lane-offset helper for flat operand buses.
package sort_sched_pkg;

   localparam int NUM_LANES = 4;

   // FSM state encoding
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] KICK    = 3'd1;
   localparam logic [2:0] WAIT_HI = 3'd2;
   localparam logic [2:0] WAIT_LO = 3'd3;
   localparam logic [2:0] RESP    = 3'd4;

   // Bit offset of requester req_idx, lane 'lane' inside a flat operand bus
   function automatic int lane_lsb(input int req_idx, input int lane, input int width);
      return (req_idx * NUM_LANES + lane) * width;
   endfunction

endpackage

// File: rtl/sort_scheduler_rr_pick.sv
// Combinational round-robin picker: searches req starting one above 'last',
// wrapping modulo NUM_REQ, and reports the first set bit as index and one-hot.
module rr_pick #(
   parameter int NUM_REQ = 4,
   localparam int IW = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      last,
   output logic               any,
   output logic [IW-1:0]      idx,
   output logic [NUM_REQ-1:0] onehot
);

   logic [IW-1:0] cand;

   // First requester at or after last+1 (modulo NUM_REQ) wins
   always_comb begin
      any    = 1'b0;
      idx    = '0;
      cand   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IW'((int'(last) + k) % NUM_REQ);
         if (!any && req[cand]) begin
            any = 1'b1;
            idx = cand;
         end
      end
      onehot = any ? (NUM_REQ'(1) << idx) : '0;
   end

endmodule

// File: rtl/sort_scheduler.sv
// sort_scheduler: shares one 4-lane sort unit between NUM_REQ requesters.
// Optional build macro SORT_SCHED_TIMEOUT_EN adds a watchdog on the sort's
// busy handshake and a sticky timeout_err output.
//
// Handshakes: a requester holds req (level) until it sees its one-cycle grant
// pulse; operands are latched in that grant cycle and a one-cycle done pulse
// marks the cycle result is valid. Toward the sort unit, sort_kick is a single
// pulse; the job is accepted once sort_busy is seen high and complete on the
// first later cycle sort_busy is seen low.
module sort_scheduler
   import sort_sched_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                           CLK,
   input  logic                           RST,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ*NUM_LANES*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]             grant,
   output logic [NUM_REQ-1:0]             done,
   output logic [NUM_LANES*WIDTH-1:0]     result,
   output logic [NUM_LANES*WIDTH-1:0]     sort_in,
   input  logic [NUM_LANES*WIDTH-1:0]     sort_out,
   output logic                           sort_kick,
   input  logic                           sort_busy,
   output logic                           sched_busy,
`ifdef SORT_SCHED_TIMEOUT_EN
   output logic                           timeout_err,
`endif
   output logic [2:0]                     dbg_state
);

   localparam int IW = $clog2(NUM_REQ);

   // Reject configurations outside the supported range at elaboration
   if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("sort_scheduler: unsupported parameter set");
   end

   logic [2:0]         state;
   logic [IW-1:0]      owner;
   logic [IW-1:0]      last;
   logic               pick_any;
   logic [IW-1:0]      pick_idx;
   logic [NUM_REQ-1:0] pick_onehot;

   assign dbg_state = state;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
      .req    (req),
      .last   (last),
      .any    (pick_any),
      .idx    (pick_idx),
      .onehot (pick_onehot)
   );

`ifdef SORT_SCHED_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] wait_cnt;
   logic          wait_expired;
   assign wait_expired = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`endif

   // Scheduler FSM: arbitrate, kick the sort, track busy, return the result
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state      <= IDLE;
         grant      <= '0;
         done       <= '0;
         sort_kick  <= 1'b0;
         sched_busy <= 1'b0;
         sort_in    <= '0;
         result     <= '0;
         owner      <= '0;
         last       <= IW'(NUM_REQ - 1);
`ifdef SORT_SCHED_TIMEOUT_EN
         wait_cnt    <= '0;
         timeout_err <= 1'b0;
`endif
      end else begin
         grant     <= '0;
         done      <= '0;
         sort_kick <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_any) begin
                  grant      <= pick_onehot;
                  sort_in    <= req_data[lane_lsb(int'(pick_idx), 0, WIDTH) +: NUM_LANES*WIDTH];
                  owner      <= pick_idx;
                  last       <= pick_idx;
                  state      <= KICK;
                  sched_busy <= 1'b1;
               end
            end
            KICK: begin
               sort_kick <= 1'b1;
               state     <= WAIT_HI;
`ifdef SORT_SCHED_TIMEOUT_EN
               wait_cnt  <= '0;
`endif
            end
            WAIT_HI: begin
               if (sort_busy) begin
                  state <= WAIT_LO;
`ifdef SORT_SCHED_TIMEOUT_EN
                  wait_cnt <= '0;
               end else if (wait_expired) begin
                  timeout_err <= 1'b1;
                  done        <= NUM_REQ'(1) << owner;
                  state       <= IDLE;
                  sched_busy  <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
`endif
               end
            end
            WAIT_LO: begin
               if (!sort_busy) begin
                  result <= sort_out;
                  state  <= RESP;
`ifdef SORT_SCHED_TIMEOUT_EN
               end else if (wait_expired) begin
                  timeout_err <= 1'b1;
                  done        <= NUM_REQ'(1) << owner;
                  state       <= IDLE;
                  sched_busy  <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
`endif
               end
            end
            RESP: begin
               done       <= NUM_REQ'(1) << owner;
               state      <= IDLE;
               sched_busy <= 1'b0;
            end
            default: begin
               state      <= IDLE;
               sched_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sort_scheduler.sv
// Directed bench for sort_scheduler with a behavioural 4-lane sort model.
// Build with +define+SORT_SCHED_TIMEOUT_EN to include the watchdog case.
module tb_sort_scheduler;
   import sort_sched_pkg::*;

   localparam int W  = 32;
   localparam int NR = 4;
   localparam int TO = 16;

   logic               CLK = 1'b0;
   logic               RST;
   logic [NR-1:0]      req;
   logic [NR*4*W-1:0]  req_data;
   logic [NR-1:0]      grant;
   logic [NR-1:0]      done;
   logic [4*W-1:0]     result;
   logic [4*W-1:0]     sort_in;
   logic [4*W-1:0]     sort_out = '0;
   logic               sort_kick;
   logic               sort_busy = 1'b0;
   logic               sched_busy;
   logic [2:0]         dbg_state;
`ifdef SORT_SCHED_TIMEOUT_EN
   logic               timeout_err;
`endif

   int vectors = 0;
   int miscompares = 0;

   // Operand sets (lanes 0..3) and their ascending sorted results
   // r0: 4,3,2,1      -> 1,2,3,4
   // r1: 10,40,30,20  -> 10,20,30,40
   // r2: 7,5,9,6      -> 5,6,7,9
   // r3: 100,0,50,25  -> 0,25,50,100
   logic [4*W-1:0] d_tab [4];
   logic [4*W-1:0] r_tab [4];
   logic [NR-1:0]  exp_q [$];

   // Clock / reset block
   always #5 CLK = ~CLK;

   sort_scheduler #(.WIDTH(W), .NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .req        (req),
      .req_data   (req_data),
      .grant      (grant),
      .done       (done),
      .result     (result),
      .sort_in    (sort_in),
      .sort_out   (sort_out),
      .sort_kick  (sort_kick),
      .sort_busy  (sort_busy),
      .sched_busy (sched_busy),
`ifdef SORT_SCHED_TIMEOUT_EN
      .timeout_err(timeout_err),
`endif
      .dbg_state  (dbg_state)
   );

   // Sort model: mode 0 answers the kick, mode 1 raises busy early (on grant),
   // mode 2 never answers. Result appears on sort_out as busy falls.
   int             model_mode = 0;
   int             busy_left = 0;
   logic [4*W-1:0] model_lat = '0;

   function automatic logic [4*W-1:0] sort4(input logic [4*W-1:0] v);
      logic [W-1:0] a [4];
      logic [W-1:0] t;
      for (int i = 0; i < 4; i++) a[i] = v[i*W +: W];
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3 - i; j++)
            if (a[j] > a[j+1]) begin
               t = a[j]; a[j] = a[j+1]; a[j+1] = t;
            end
      return {a[3], a[2], a[1], a[0]};
   endfunction

   always @(posedge CLK) begin
      if (busy_left > 0) begin
         if (busy_left == 1) begin
            sort_busy <= 1'b0;
            sort_out  <= sort4(model_lat);
         end
         busy_left <= busy_left - 1;
      end else if ((model_mode == 0 && sort_kick) || (model_mode == 1 && |grant)) begin
         sort_busy <= 1'b1;
         busy_left <= (model_mode == 0) ? 5 : 3;
         model_lat <= sort_in;
      end
   end

   // Scoreboard compare
   task automatic chk(input string tag, input logic [4*W-1:0] obs, input logic [4*W-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Driver: raise req, wait (bounded) for a grant, check winner and operands
   task automatic do_grant(input logic [NR-1:0] req_v, input logic [NR-1:0] exp_g,
                           input logic [4*W-1:0] exp_in, input string tag);
      int n;
      req = req_v;
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!(|grant) && n < 8);
      chk({tag, "_grant"}, grant, exp_g);
      chk({tag, "_sort_in"}, sort_in, exp_in);
   endtask

   // Wait (bounded) for done, check owner and result; returns cycles waited
   task automatic do_done(input logic [NR-1:0] exp_d, input logic [4*W-1:0] exp_r,
                          input string tag, output int lat);
      int n;
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!(|done) && n < 40);
      lat = n;
      chk({tag, "_done"}, done, exp_d);
      chk({tag, "_result"}, result, exp_r);
   endtask

   initial begin
      int lat;
      int n;
      logic any_done;
      logic [NR-1:0] g;

      d_tab[0] = {32'd1,  32'd2,  32'd3, 32'd4};
      d_tab[1] = {32'd20, 32'd30, 32'd40, 32'd10};
      d_tab[2] = {32'd6,  32'd9,  32'd5, 32'd7};
      d_tab[3] = {32'd25, 32'd50, 32'd0, 32'd100};
      r_tab[0] = {32'd4,  32'd3,  32'd2, 32'd1};
      r_tab[1] = {32'd40, 32'd30, 32'd20, 32'd10};
      r_tab[2] = {32'd9,  32'd7,  32'd6, 32'd5};
      r_tab[3] = {32'd100, 32'd50, 32'd25, 32'd0};
      req_data = {d_tab[3], d_tab[2], d_tab[1], d_tab[0]};

      // Reset state
      RST = 1'b1;
      req = '0;
      #2 RST = 1'b0;
      #1;
      chk("rst_grant", grant, '0);
      chk("rst_done", done, '0);
      chk("rst_kick", sort_kick, '0);
      chk("rst_sched_busy", sched_busy, '0);
      chk("rst_result", result, '0);
      chk("rst_sort_in", sort_in, '0);
      chk("rst_state", dbg_state, IDLE);
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);

      // Single request with exact latency
      do_grant(4'b0001, 4'b0001, d_tab[0], "single");
      req = '0;
      chk("single_sched_busy", sched_busy, 1'b1);
      chk("single_kick_lo_at_grant", sort_kick, 1'b0);
      @(negedge CLK);
      chk("single_kick_hi", sort_kick, 1'b1);
      chk("single_grant_pulse", grant, '0);
      @(negedge CLK);
      chk("single_kick_one_cycle", sort_kick, 1'b0);
      do_done(4'b0001, r_tab[0], "single", lat);
      chk("single_done_latency", lat, 7);
      chk("single_idle_at_done", sched_busy, 1'b0);
      @(negedge CLK);
      chk("single_done_pulse", done, '0);
      chk("single_result_hold", result, r_tab[0]);

      // Withdrawal: req[2] pulsed while busy must not be served
      do_grant(4'b1000, 4'b1000, d_tab[3], "wd_first");
      req = '0;
      @(negedge CLK);
      req = 4'b0100;
      @(negedge CLK);
      req = '0;
      do_done(4'b1000, r_tab[3], "wd_first", lat);
      do_grant(4'b0010, 4'b0010, d_tab[1], "wd_next");
      req = '0;
      do_done(4'b0010, r_tab[1], "wd_next", lat);

      // Reset in the middle of a job
      do_grant(4'b0001, 4'b0001, d_tab[0], "midrst");
      req = '0;
      n = 0;
      while (dbg_state !== WAIT_LO && n < 20) begin
         @(negedge CLK);
         n++;
      end
      chk("midrst_reach_wait_lo", dbg_state, WAIT_LO);
      RST = 1'b0;
      #1;
      chk("midrst_state", dbg_state, IDLE);
      chk("midrst_sched_busy", sched_busy, '0);
      chk("midrst_result", result, '0);
      chk("midrst_sort_in", sort_in, '0);
      chk("midrst_done", done, '0);
      @(negedge CLK);
      RST = 1'b1;
      any_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge CLK);
         any_done = any_done | (|done);
      end
      chk("midrst_no_done", any_done, 1'b0);
      do_grant(4'b1000, 4'b1000, d_tab[3], "after_rst");
      req = '0;
      do_done(4'b1000, r_tab[3], "after_rst", lat);

      // Contention: all requesting, held continuously
      exp_q.push_back(4'b0001);
      exp_q.push_back(4'b0010);
      exp_q.push_back(4'b0100);
      exp_q.push_back(4'b1000);
      exp_q.push_back(4'b0001);
      while (exp_q.size() > 0) begin
         g = exp_q.pop_front();
         do_grant(4'b1111, g, d_tab[$clog2(g)], "rr");
         if (exp_q.size() == 0) req = '0;
         do_done(g, r_tab[$clog2(g)], "rr", lat);
      end

      // Busy already high when WAIT_HI is entered
      model_mode = 1;
      do_grant(4'b0100, 4'b0100, d_tab[2], "early_busy");
      req = '0;
      @(negedge CLK);
      chk("early_busy_wait_hi", dbg_state, WAIT_HI);
      @(negedge CLK);
      chk("early_busy_wait_lo", dbg_state, WAIT_LO);
      do_done(4'b0100, r_tab[2], "early_busy", lat);
      model_mode = 0;

`ifdef SORT_SCHED_TIMEOUT_EN
      // Watchdog: busy never rises
      model_mode = 2;
      do_grant(4'b0010, 4'b0010, d_tab[1], "timeout");
      req = '0;
      chk("timeout_err_before", timeout_err, 1'b0);
      do_done(4'b0010, r_tab[2], "timeout", lat);
      chk("timeout_latency", lat, 17);
      chk("timeout_err_set", timeout_err, 1'b1);
      model_mode = 0;
      do_grant(4'b0001, 4'b0001, d_tab[0], "post_timeout");
      req = '0;
      do_done(4'b0001, r_tab[0], "post_timeout", lat);
      chk("timeout_err_sticky", timeout_err, 1'b1);
`endif

      @(negedge CLK);
      chk("final_idle", dbg_state, IDLE);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
